// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD issue front-end.
package gcd_pkg;

  localparam int unsigned GCD_DATA_WIDTH     = 8;
  localparam int unsigned GCD_FIFO_DEPTH     = 4;
  localparam int unsigned GCD_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO holding {a,b} operand pairs; DEPTH must be a power of two.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * GCD_DATA_WIDTH,
  parameter int unsigned DEPTH = GCD_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem[rd_ptr_q];
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

endmodule

// File: rtl/gcd_issue_ctrl.sv
// Buffers operand pairs and issues them one at a time to the GCD core, capturing results in order.
// Optional watchdog on a stalled core: define GCD_ISSUE_TIMEOUT_EN.
module gcd_issue_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = GCD_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = GCD_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  output logic [DATA_WIDTH-1:0] core_operand_a_o,
  output logic [DATA_WIDTH-1:0] core_operand_b_o,
  output logic                  core_enable_o,
  input  logic [DATA_WIDTH-1:0] core_gcd_i,
  input  logic                  core_done_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_gcd_o,
  output logic                  res_err_o
);

  logic                    fifo_full_c;
  logic                    fifo_empty_c;
  logic                    push_c;
  logic                    pop_c;
  logic                    res_free_c;
  logic [2*DATA_WIDTH-1:0] head_c;
  logic [DATA_WIDTH-1:0]   head_a_c;
  logic [DATA_WIDTH-1:0]   head_b_c;

  gcd_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  en_q, en_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_gcd_q, res_gcd_d;

`ifdef GCD_ISSUE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            res_err_q, res_err_d;
  logic            timeout_c;
  assign timeout_c = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  gcd_req_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (nreset_i),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   ({req_a_i, req_b_i}),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign req_ready_o = !fifo_full_c;
  assign push_c      = req_valid_i && !fifo_full_c;
  assign head_a_c    = head_c[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_b_c    = head_c[DATA_WIDTH-1:0];
  assign res_free_c  = !res_valid_q || res_ready_i;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_gcd_q   <= '0;
`ifdef GCD_ISSUE_TIMEOUT_EN
      to_cnt_q    <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      en_q        <= en_d;
      res_valid_q <= res_valid_d;
      res_gcd_q   <= res_gcd_d;
`ifdef GCD_ISSUE_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  // Next state, pop decision and result-register update.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    en_d        = en_q;
    res_valid_d = res_valid_q && !res_ready_i;
    res_gcd_d   = res_gcd_q;
    pop_c       = 1'b0;
`ifdef GCD_ISSUE_TIMEOUT_EN
    to_cnt_d    = '0;
    res_err_d   = res_err_q && res_valid_d;
`endif
    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (!fifo_empty_c && !core_done_i && res_free_c) begin
          pop_c = 1'b1;
          if (head_a_c == '0 || head_b_c == '0) begin
            res_gcd_d   = head_a_c | head_b_c;
            res_valid_d = 1'b1;
`ifdef GCD_ISSUE_TIMEOUT_EN
            res_err_d   = 1'b0;
`endif
          end else begin
            op_a_d  = head_a_c;
            op_b_d  = head_b_c;
            en_d    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        en_d = 1'b1;
`ifdef GCD_ISSUE_TIMEOUT_EN
        to_cnt_d = timeout_c ? to_cnt_q : to_cnt_q + TO_W'(1);
`endif
        if (core_done_i && res_free_c) begin
          res_gcd_d   = core_gcd_i;
          res_valid_d = 1'b1;
          en_d        = 1'b0;
          state_d     = ST_RELEASE;
`ifdef GCD_ISSUE_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
`ifdef GCD_ISSUE_TIMEOUT_EN
        else if (timeout_c && res_free_c) begin
          res_gcd_d   = '0;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          en_d        = 1'b0;
          state_d     = ST_RELEASE;
        end
`endif
      end
      ST_RELEASE: begin
        en_d = 1'b0;
        if (!core_done_i) state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign core_operand_a_o = op_a_q;
  assign core_operand_b_o = op_b_q;
  assign core_enable_o    = en_q;
  assign res_valid_o      = res_valid_q;
  assign res_gcd_o        = res_gcd_q;
`ifdef GCD_ISSUE_TIMEOUT_EN
  assign res_err_o        = res_err_q;
`else
  assign res_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_issue_ctrl.sv
// Self-checking bench for gcd_issue_ctrl: behavioural GCD core plus an in-order result scoreboard.
module tb_gcd_issue_ctrl;

  localparam int unsigned DW         = 8;
  localparam int unsigned TB_TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [DW-1:0] req_a_i, req_b_i;
  logic [DW-1:0] core_operand_a_o, core_operand_b_o;
  logic          core_enable_o;
  logic [DW-1:0] core_gcd_i;
  logic          core_done_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [DW-1:0] res_gcd_o;
  logic          res_err_o;

  int n_cmp = 0;
  int n_fail = 0;
  int en_rises = 0;
  int exp_issue = 0;
  int last_push = 0;
  int core_lat = 2;
  int core_cnt;
  logic core_stuck = 1'b0;
  logic [DW:0] exp_q[$];

  gcd_issue_ctrl #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk_i            (clk_i),
    .nreset_i         (nreset_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_a_i          (req_a_i),
    .req_b_i          (req_b_i),
    .core_operand_a_o (core_operand_a_o),
    .core_operand_b_o (core_operand_b_o),
    .core_enable_o    (core_enable_o),
    .core_gcd_i       (core_gcd_i),
    .core_done_i      (core_done_i),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .res_gcd_o        (res_gcd_o),
    .res_err_o        (res_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return DW'(x);
  endfunction

  // Core model: done is sampled by the controller core_lat edges after enable rises; held until enable drops.
  always @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      core_done_i <= 1'b0;
      core_gcd_i  <= '0;
      core_cnt    <= 0;
    end else if (core_enable_o) begin
      if (!core_done_i) begin
        if (!core_stuck && core_cnt + 2 >= core_lat) begin
          core_done_i <= 1'b1;
          core_gcd_i  <= ref_gcd(core_operand_a_o, core_operand_b_o);
        end
        core_cnt <= core_cnt + 1;
      end
    end else begin
      core_done_i <= 1'b0;
      core_cnt    <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: records accepted requests, scores transferred results, checks hold rules.
  task automatic tick();
    logic          xfer, push, en_prev, hold;
    logic [DW:0]   got, pre_res;
    logic [DW-1:0] pa, pb, opa, opb;
    logic [DW:0]   exp;
    xfer    = nreset_i && res_valid_o && res_ready_i;
    hold    = nreset_i && res_valid_o && !res_ready_i;
    got     = {res_err_o, res_gcd_o};
    pre_res = got;
    push    = nreset_i && req_valid_i && req_ready_o;
    pa      = req_a_i;
    pb      = req_b_i;
    en_prev = core_enable_o;
    opa     = core_operand_a_o;
    opb     = core_operand_b_o;
    @(posedge clk_i);
    #1;
    last_push = 0;
    if (push) begin
      exp_q.push_back({1'b0, ref_gcd(pa, pb)});
      if (pa != '0 && pb != '0) exp_issue++;
      last_push = 1;
    end
    if (xfer) begin
      check("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("result", 32'(got), 32'(exp));
      end
    end
    if (!en_prev && core_enable_o) en_rises++;
    if (en_prev && core_enable_o)
      check("operands_stable", 32'({core_operand_a_o, core_operand_b_o}), 32'({opa, opb}));
    if (hold)
      check("result_held", 32'({res_valid_o, res_err_o, res_gcd_o}), 32'({1'b1, pre_res}));
  endtask

  task automatic drain(input int budget);
    int k;
    res_ready_i = 1'b1;
    k = 0;
    while ((exp_q.size() > 0 || res_valid_o) && k < budget) begin
      tick();
      k++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_one(input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a_i = a;
    req_b_i = b;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    int n, pushed, r0, i0;

    // Reset with a request pending.
    nreset_i = 1'b0; req_valid_i = 1'b1; req_a_i = 8'd5; req_b_i = 8'd3; res_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res_err", 32'(res_err_o), 32'd0);
    check("rst_enable", 32'(core_enable_o), 32'd0);
    check("rst_operands", 32'({core_operand_a_o, core_operand_b_o}), 32'd0);
    check("rst_res_gcd", 32'(res_gcd_o), 32'd0);
    req_valid_i = 1'b0;
    nreset_i = 1'b1;
    repeat (4) tick();
    check("idle_no_issue", 32'(core_enable_o), 32'd0);
    check("idle_req_ready", 32'(req_ready_o), 32'd1);
    check("idle_res_valid", 32'(res_valid_o), 32'd0);

    // gcd(48,18) with a 10-cycle core.
    core_lat = 10;
    push_one(8'd48, 8'd18);
    tick();
    check("issue_latency_en", 32'(core_enable_o), 32'd1);
    check("issue_operands", 32'({core_operand_a_o, core_operand_b_o}), 32'({8'd48, 8'd18}));
    n = 1;
    while (core_enable_o && n < 200) begin
      tick();
      if (core_enable_o) n++;
    end
    check("enable_high_cycles", 32'(n), 32'd10);
    check("core_res_valid", 32'(res_valid_o), 32'd1);
    check("core_res_gcd", 32'(res_gcd_o), 32'd6);
    drain(50);

    // Zero-operand bypass.
    core_lat = 3;
    r0 = en_rises;
    push_one(8'd0, 8'd5);
    tick();
    check("bypass_latency_valid", 32'(res_valid_o), 32'd1);
    check("bypass_latency_gcd", 32'(res_gcd_o), 32'd5);
    res_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_a_i = 8'd0; req_b_i = 8'd0; tick();
    req_a_i = 8'd0; req_b_i = 8'd7; tick();
    req_a_i = 8'd9; req_b_i = 8'd0; tick();
    req_valid_i = 1'b0;
    drain(50);
    check("bypass_no_enable", 32'(en_rises - r0), 32'd0);

    // Fill the FIFO behind a full result register, then drain with continuous push/pop.
    res_ready_i = 1'b0;
    r0 = en_rises;
    pushed = 0;
    for (int k = 0; k < 30 && pushed < 6; k++) begin
      if (!req_valid_i) begin
        req_a_i = 8'($urandom_range(1, 255));
        req_b_i = 8'($urandom_range(1, 255));
        req_valid_i = 1'b1;
      end
      tick();
      if (last_push != 0) begin pushed++; req_valid_i = 1'b0; end
    end
    check("fill_pushed", 32'(pushed), 32'd5);
    check("fill_req_ready_low", 32'(req_ready_o), 32'd0);
    check("fill_res_valid", 32'(res_valid_o), 32'd1);
    check("fill_single_issue", 32'(en_rises - r0), 32'd1);
    res_ready_i = 1'b1;
    for (int k = 0; k < 400 && pushed < 18; k++) begin
      if (!req_valid_i) begin
        req_a_i = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        req_b_i = 8'($urandom_range(1, 255));
        req_valid_i = 1'b1;
      end
      tick();
      if (last_push != 0) begin pushed++; req_valid_i = 1'b0; end
    end
    req_valid_i = 1'b0;
    check("wrap_pushed", 32'(pushed), 32'd18);
    drain(600);

    // Randomised traffic with consumer back-pressure and varying core latency.
    r0 = en_rises;
    i0 = exp_issue;
    for (int k = 0; k < 500; k++) begin
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_a_i = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      req_b_i = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      res_ready_i = ($urandom_range(0, 3) != 0);
      core_lat = int'($urandom_range(2, 6));
      tick();
    end
    req_valid_i = 1'b0;
    drain(1000);
    check("random_issue_count", 32'(en_rises - r0), 32'(exp_issue - i0));

    // Reset in the middle of a core operation.
    core_lat = 50;
    res_ready_i = 1'b0;
    push_one(8'd100, 8'd75);
    push_one(8'd30, 8'd12);
    repeat (3) tick();
    check("midrst_pre_enable", 32'(core_enable_o), 32'd1);
    nreset_i = 1'b0;
    #1;
    check("midrst_enable", 32'(core_enable_o), 32'd0);
    check("midrst_operands", 32'({core_operand_a_o, core_operand_b_o}), 32'd0);
    check("midrst_req_ready", 32'(req_ready_o), 32'd1);
    exp_q.delete();
    repeat (2) tick();
    nreset_i = 1'b1;
    repeat (4) tick();
    check("midrst_fifo_flushed", 32'(core_enable_o), 32'd0);
    check("midrst_no_result", 32'(res_valid_o), 32'd0);
    core_lat = 4;
    push_one(8'd21, 8'd14);
    drain(100);

`ifdef GCD_ISSUE_TIMEOUT_EN
    // Stalled core: watchdog aborts with an error result.
    core_stuck = 1'b1;
    res_ready_i = 1'b0;
    push_one(8'd12, 8'd8);
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = {1'b1, 8'd0};
    tick();
    n = 1;
    while (core_enable_o && n < 200) begin
      tick();
      if (core_enable_o) n++;
    end
    check("timeout_enable_cycles", 32'(n), 32'(TB_TIMEOUT));
    check("timeout_res_valid", 32'(res_valid_o), 32'd1);
    check("timeout_res_err", 32'(res_err_o), 32'd1);
    check("timeout_res_gcd", 32'(res_gcd_o), 32'd0);
    core_stuck = 1'b0;
    drain(100);
    push_one(8'd12, 8'd8);
    drain(100);
    check("post_timeout_err", 32'(res_err_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
